gcd_multi_ch: RTL
=================

Name: gcd_multi_ch

Overview:
- Parametrised successor of the single-channel GCD engine: NUM_CH independent request channels share one iterative binary (Stein) GCD datapath.
- Each channel has its own valid/ready operand handshake and result handshake.
- Sits between the SPI register file and the top level, replacing the single gcd_enable/gcd_done pair.
- Round-robin arbitration guarantees each pending channel service within NUM_CH jobs.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (>=2)
- NUM_CH, 4, number of request channels (>=1)
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_CH  per-channel operand valid
- req_ready_o  out  NUM_CH  per-channel operand ready
- operand_a_i  in  NUM_CH*DATA_WIDTH  channel c operand A at [c*DATA_WIDTH +: DATA_WIDTH]
- operand_b_i  in  NUM_CH*DATA_WIDTH  channel c operand B, same packing
- res_valid_o  out  NUM_CH  per-channel result valid
- res_ready_i  in  NUM_CH  per-channel result consumed
- gcd_o  out  NUM_CH*DATA_WIDTH  per-channel result, same packing
- busy_o  out  1  core computing
- active_ch_o  out  CH_W  channel currently owning the core (0 when idle)

Behaviour:
- Reset (async assert, sync release): all slots EMPTY, core IDLE, round-robin pointer = NUM_CH-1 (so channel 0 wins first). Output reset values: req_ready_o all 1; res_valid_o, gcd_o, busy_o, active_ch_o all 0.
- Slot FSM per channel: EMPTY -> PENDING -> RUNNING -> DONE -> EMPTY.
  - req_ready_o[c] = (slot==EMPTY).
  - req_valid&ready latches A,B into slot registers; slot goes PENDING next cycle.
  - res_valid_o[c] = (slot==DONE); gcd_o holds the latched result while DONE.
  - res_valid&res_ready returns slot to EMPTY; a new request can be accepted from the following cycle.
  - No same-cycle DONE->accept bypass.
- Arbiter: when core IDLE and any slot PENDING, grant the first PENDING channel after the pointer (wrapping). The grant cycle loads the core, sets the slot RUNNING and updates the pointer to the granted channel. A request accepted on the same edge the core goes idle is eligible next cycle.
- Core FSM: IDLE, STRIP, REDUCE, FINISH.
  - Load: a,b <- operands, k <- 0.
  - a==0 or b==0: go directly to FINISH with result = a|b. gcd(0,0)=0.
  - STRIP: while a,b both even: a>>=1, b>>=1, k++ (one step/cycle).
  - REDUCE, one step/cycle: a even -> a>>=1; else b even -> b>>=1; else a>=b -> a=(a-b)>>1; else b=(b-a)>>1.
  - Exit REDUCE when a==0 (result b<<k) or b==0 (result a<<k).
  - FINISH: write result into owning slot, slot DONE, core IDLE the same edge.
  - k width = $clog2(DATA_WIDTH)+1. Shift result fits DATA_WIDTH; no overflow possible.
- Latency from grant to res_valid: <= 2*DATA_WIDTH+2 cycles; exactly 2 cycles for a zero operand.
- busy_o high in STRIP/REDUCE/FINISH. active_ch_o holds the granted index during those states.
- Core runs a job to completion even if its slot's res_ready is held low. Other channels' handshakes continue independently.
- Reset mid-operation: all jobs are discarded; no partial result is ever presented.

Optional Feature:
- Macro GCD_MULTI_CH_PERF_CNT_EN.
- Defined:
  - Adds output cycles_o [NUM_CH*16].
  - Per-channel 16-bit count of core cycles (grant to FINISH inclusive) for the last completed job, saturating at 16'hFFFF.
  - Updated together with the slot going DONE; reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package gcd_multi_pkg:
  - slot_state_t enum (EMPTY, PENDING, RUNNING, DONE)
  - core_state_t enum (IDLE, STRIP, REDUCE, FINISH)
  - DATA_WIDTH_DEFAULT, NUM_CH_DEFAULT
  - function rr_pick(pending, ptr) returning the next index
- Sub-module gcd_stein_core:
  - Contains the core FSM and datapath.
  - Interface: start_i, a_i, b_i, done_o (1-cycle pulse), result_o, busy_o.
- gcd_multi_ch holds the slots, arbiter and optional counters.

Test Plan:
- Ch0 req A=12,B=18 -> res_valid_o[0] within 18 cycles of grant, gcd_o ch0 = 6; req_ready_o[0] low until res_ready_i[0] accepted.
- Zero operands: ch1 (0,35) -> 35; ch1 (0,0) -> 0; each with res_valid exactly 2 cycles after grant.
- All 4 channels request in the same cycle: (48,36), (17,5), (128,64), (255,85) -> grants in order 0,1,2,3; results 12, 1, 64, 85; active_ch_o follows the grant order.
- Fairness: ch0 re-requests immediately after every result while ch2 is pending -> ch2 granted before ch0's second job.
- Backpressure: hold res_ready_i[3]=0 for 50 cycles -> res_valid_o[3] and gcd_o stable; other channels complete normally; slot 3 rejects new requests (ready=0).
- Assert reset_i mid-REDUCE -> all outputs return to reset values immediately; a subsequent (100,75) on ch0 returns 25. With PERF_CNT_EN defined, cycles_o ch0 is nonzero, <= 18, and 0 after reset.

Source files
------------

// File: rtl/gcd_multi_pkg.sv
// Shared types, defaults and the round-robin pick helper for the multi-channel GCD engine.
// No ports; imported by gcd_stein_core and gcd_multi_ch.
package gcd_multi_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned NUM_CH_DEFAULT     = 4;
  // Upper bound on channel count handled by rr_pick.
  localparam int unsigned MAX_CH             = 32;

  typedef enum logic [1:0] {Empty, Pending, Running, Done} slot_state_t;
  typedef enum logic [1:0] {Idle, Strip, Reduce, Finish} core_state_t;

  // First set bit of pending strictly after ptr, wrapping at num_ch.
  // Returns ptr when nothing is pending; callers gate with |pending.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] pending,
                                          input int unsigned         ptr,
                                          input int unsigned         num_ch);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      if (i <= num_ch) begin
        idx = ptr + i;
        if (idx >= num_ch) idx = idx - num_ch;
        if (!found && pending[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gcd_stein_core.sv
// Iterative binary (Stein) GCD datapath, one step per cycle.
// Ports:
//   clk_i, reset_i (async active-high)
//   start_i       load a_i/b_i; only honoured while idle
//   a_i, b_i      operands
//   done_o        high for the single FINISH cycle; result_o valid then
//   result_o      gcd(a, b)
//   busy_o        high in STRIP/REDUCE/FINISH
module gcd_stein_core import gcd_multi_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  localparam int unsigned KW = $clog2(DATA_WIDTH) + 1;

  core_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic [KW-1:0]         r_k;

  logic [DATA_WIDTH-1:0] w_a_step;
  logic [DATA_WIDTH-1:0] w_b_step;

  // One REDUCE step; entered with at least one operand odd and both nonzero.
  always_comb begin
    w_a_step = r_a;
    w_b_step = r_b;
    if (!r_a[0]) begin
      w_a_step = r_a >> 1;
    end else if (!r_b[0]) begin
      w_b_step = r_b >> 1;
    end else if (r_a >= r_b) begin
      w_a_step = (r_a - r_b) >> 1;
    end else begin
      w_b_step = (r_b - r_a) >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= Idle;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        Idle: begin
          if (start_i) begin
            r_a <= a_i;
            r_b <= b_i;
            r_k <= '0;
            if (a_i == '0 || b_i == '0) begin
              r_result <= a_i | b_i;
              r_state  <= Finish;
            end else begin
              r_state <= Strip;
            end
          end
        end
        Strip: begin
          if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + 1'b1;
          end else begin
            r_state <= Reduce;
          end
        end
        Reduce: begin
          r_a <= w_a_step;
          r_b <= w_b_step;
          // Exit on the step that zeroes an operand, saving a detection cycle.
          if (w_a_step == '0) begin
            r_result <= w_b_step << r_k;
            r_state  <= Finish;
          end else if (w_b_step == '0) begin
            r_result <= w_a_step << r_k;
            r_state  <= Finish;
          end
        end
        Finish: r_state <= Idle;
        default: r_state <= Idle;
      endcase
    end
  end

  assign done_o   = (r_state == Finish);
  assign busy_o   = (r_state != Idle);
  assign result_o = r_result;

endmodule

// File: rtl/gcd_multi_ch.sv
// NUM_CH request channels sharing one Stein GCD core under round-robin arbitration.
// Each channel owns a slot (EMPTY -> PENDING -> RUNNING -> DONE -> EMPTY).
// Ports:
//   clk_i, reset_i (async active-high)
//   req_valid_i/req_ready_o   per-channel operand handshake
//   operand_a_i/operand_b_i   channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   res_valid_o/res_ready_i   per-channel result handshake
//   gcd_o                     per-channel result, same packing
//   busy_o, active_ch_o       core activity and owning channel (0 when idle)
// Optional: define GCD_MULTI_CH_PERF_CNT_EN to add cycles_o [NUM_CH*16], the
// saturating grant-to-FINISH cycle count of each channel's last completed job.
// NUM_CH must not exceed gcd_multi_pkg::MAX_CH.
module gcd_multi_ch import gcd_multi_pkg::*; #(
  parameter int unsigned  DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned  NUM_CH     = NUM_CH_DEFAULT,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] operand_a_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] operand_b_i,
  output logic [NUM_CH-1:0]            res_valid_o,
  input  logic [NUM_CH-1:0]            res_ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] gcd_o,
  output logic                         busy_o,
  output logic [CH_W-1:0]              active_ch_o
`ifdef GCD_MULTI_CH_PERF_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]         cycles_o
`endif
);

  slot_state_t           r_slot [NUM_CH];
  logic [DATA_WIDTH-1:0] r_op_a [NUM_CH];
  logic [DATA_WIDTH-1:0] r_op_b [NUM_CH];
  logic [DATA_WIDTH-1:0] r_res  [NUM_CH];
  logic [CH_W-1:0]       r_ptr;
  logic [CH_W-1:0]       r_active_ch;

  logic [NUM_CH-1:0]     w_pending;
  logic                  w_grant;
  logic [CH_W-1:0]       w_grant_ch;
  logic                  w_core_done;
  logic                  w_core_busy;
  logic [DATA_WIDTH-1:0] w_core_result;

  always_comb begin
    w_pending   = '0;
    req_ready_o = '0;
    res_valid_o = '0;
    gcd_o       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pending[c]                        = (r_slot[c] == Pending);
      req_ready_o[c]                      = (r_slot[c] == Empty);
      res_valid_o[c]                      = (r_slot[c] == Done);
      gcd_o[c*DATA_WIDTH +: DATA_WIDTH]   = r_res[c];
    end
  end

  assign w_grant    = !w_core_busy && (|w_pending);
  assign w_grant_ch = CH_W'(rr_pick(MAX_CH'(w_pending), 32'(r_ptr), NUM_CH));

  gcd_stein_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (w_grant),
    .a_i      (r_op_a[w_grant_ch]),
    .b_i      (r_op_b[w_grant_ch]),
    .done_o   (w_core_done),
    .result_o (w_core_result),
    .busy_o   (w_core_busy)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_slot[c] <= Empty;
        r_op_a[c] <= '0;
        r_op_b[c] <= '0;
        r_res[c]  <= '0;
      end
      // Pointer starts on the last channel so channel 0 wins the first grant.
      r_ptr       <= CH_W'(NUM_CH - 1);
      r_active_ch <= '0;
    end else begin
      // Grant needs an idle core, done means FINISH: they never coincide.
      if (w_grant) begin
        r_ptr       <= w_grant_ch;
        r_active_ch <= w_grant_ch;
      end else if (w_core_done) begin
        r_active_ch <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        case (r_slot[c])
          Empty: begin
            if (req_valid_i[c]) begin
              r_op_a[c] <= operand_a_i[c*DATA_WIDTH +: DATA_WIDTH];
              r_op_b[c] <= operand_b_i[c*DATA_WIDTH +: DATA_WIDTH];
              r_slot[c] <= Pending;
            end
          end
          Pending: begin
            if (w_grant && w_grant_ch == CH_W'(c)) r_slot[c] <= Running;
          end
          Running: begin
            if (w_core_done && r_active_ch == CH_W'(c)) begin
              r_res[c]  <= w_core_result;
              r_slot[c] <= Done;
            end
          end
          Done: begin
            if (res_ready_i[c]) r_slot[c] <= Empty;
          end
          default: r_slot[c] <= Empty;
        endcase
      end
    end
  end

  assign busy_o      = w_core_busy;
  assign active_ch_o = r_active_ch;

`ifdef GCD_MULTI_CH_PERF_CNT_EN
  logic [15:0] r_job_cnt;
  logic [15:0] r_cycles [NUM_CH];

  // r_job_cnt counts the grant cycle plus every busy cycle before the current one,
  // so the FINISH cycle stores r_job_cnt + 1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_job_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) r_cycles[c] <= '0;
    end else begin
      if (w_grant) begin
        r_job_cnt <= 16'd1;
      end else if (w_core_busy && r_job_cnt != 16'hFFFF) begin
        r_job_cnt <= r_job_cnt + 16'd1;
      end
      if (w_core_done) begin
        r_cycles[r_active_ch] <= (r_job_cnt == 16'hFFFF) ? 16'hFFFF : r_job_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    cycles_o = '0;
    for (int c = 0; c < NUM_CH; c++) cycles_o[c*16 +: 16] = r_cycles[c];
  end
`endif

endmodule
